mem_wait_bridge: RTL and testbench

Memory-side stage directly downstream of the core's memory controller. It consumes the controller's single-cycle memory strobes (address, write data, read/write enable) and returns read data. It converts them into a req/ack handshake toward an external variable-latency memory, stretches the access until acknowledged, and flags accesses that time out. It exposes busy/done so the core can stall while an access is outstanding.

---
 rtl/mem_wait_bridge.sv | 102 ++++++++++
 tb/tb_mem_wait_bridge.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_wait_bridge.sv
// rtl/mem_wait_bridge.sv - single-cycle memory strobes to req/ack external memory bridge
//
// Purpose: accepts one-cycle read/write strobes from the memory controller,
// holds a request toward a variable-latency external memory until it is
// acknowledged or times out, then reports completion for one cycle.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   i_mem_r_en/w_en    read/write strobes from the memory controller
//   i_mem_addr/w_data  access address and write data
//   o_mem_r_data       read data returned upstream (all-ones on read timeout)
//   o_busy             access outstanding, upstream must stall
//   o_done, o_err      completion pulse, error pulse on timeout
//   o_ext_req/we       external request and direction (1 = write)
//   o_ext_addr/w_data  registered address and write data toward external memory
//   i_ext_ack          external completion, only honoured while o_ext_req
//   i_ext_r_data       external read data, valid with i_ext_ack
module mem_wait_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255,
  parameter int TO_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_mem_r_en,
  input  logic                  i_mem_w_en,
  input  logic [DATA_WIDTH-1:0] i_mem_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_w_data,
  output logic [DATA_WIDTH-1:0] o_mem_r_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic                  o_ext_req,
  output logic                  o_ext_we,
  output logic [DATA_WIDTH-1:0] o_ext_addr,
  output logic [DATA_WIDTH-1:0] o_ext_w_data,
  input  logic                  i_ext_ack,
  input  logic [DATA_WIDTH-1:0] i_ext_r_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [1:0]      state;
  logic [TO_W-1:0] to_cnt;
  logic            err_q;
  logic            any_en;

  assign any_en = i_mem_r_en | i_mem_w_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      to_cnt       <= '0;
      err_q        <= 1'b0;
      o_ext_we     <= 1'b0;
      o_ext_addr   <= '0;
      o_ext_w_data <= '0;
      o_mem_r_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_en) begin
            // A simultaneous read and write collapses into the write.
            o_ext_addr   <= i_mem_addr;
            o_ext_w_data <= i_mem_w_data;
            o_ext_we     <= i_mem_w_en;
            to_cnt       <= '0;
            err_q        <= 1'b0;
            state        <= S_REQ;
          end
        end
        S_REQ: begin
          if (i_ext_ack) begin
            if (!o_ext_we) o_mem_r_data <= i_ext_r_data;
            state <= S_DONE;
          end else if (to_cnt == TO_LAST) begin
            err_q <= 1'b1;
            if (!o_ext_we) o_mem_r_data <= '1;
            state <= S_DONE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        // Enables are deliberately not sampled here so a strobe still held
        // from the completed access is not issued a second time.
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_ext_req = (state == S_REQ);
  assign o_done    = (state == S_DONE);
  assign o_err     = (state == S_DONE) & err_q;
  // Stall starts in the issuing cycle; forced low while reset is asserted.
  assign o_busy    = rst_n & ((state == S_REQ) | ((state == S_IDLE) & any_en));

endmodule

// File: tb/tb_mem_wait_bridge.sv
// tb/tb_mem_wait_bridge.sv - directed self-checking bench for mem_wait_bridge
module tb_mem_wait_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        r_en = 1'b0, w_en = 1'b0, ack = 1'b0;
  logic        t_r_en = 1'b0, t_ack = 1'b0;
  logic [31:0] addr = '0, wdata = '0, rdata_in = '0;

  logic [31:0] r_data, ext_addr, ext_wdata;
  logic        busy, done, err, ext_req, ext_we;
  logic [31:0] t_r_data, t_ext_addr, t_ext_wdata;
  logic        t_busy, t_done, t_err, t_ext_req, t_ext_we;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_wait_bridge #(.DATA_WIDTH(32), .TIMEOUT(255), .TO_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_mem_r_en(r_en), .i_mem_w_en(w_en),
    .i_mem_addr(addr), .i_mem_w_data(wdata),
    .o_mem_r_data(r_data), .o_busy(busy), .o_done(done), .o_err(err),
    .o_ext_req(ext_req), .o_ext_we(ext_we),
    .o_ext_addr(ext_addr), .o_ext_w_data(ext_wdata),
    .i_ext_ack(ack), .i_ext_r_data(rdata_in)
  );

  mem_wait_bridge #(.DATA_WIDTH(32), .TIMEOUT(4), .TO_W(8)) dut_to (
    .clk(clk), .rst_n(rst_n),
    .i_mem_r_en(t_r_en), .i_mem_w_en(1'b0),
    .i_mem_addr(addr), .i_mem_w_data(wdata),
    .o_mem_r_data(t_r_data), .o_busy(t_busy), .o_done(t_done), .o_err(t_err),
    .o_ext_req(t_ext_req), .o_ext_we(t_ext_we),
    .o_ext_addr(t_ext_addr), .o_ext_w_data(t_ext_wdata),
    .i_ext_ack(t_ack), .i_ext_r_data(rdata_in)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    step();
    step();
    chk("rst_req", 32'(ext_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata", r_data, 32'h0);
    chk("rst_addr", ext_addr, 32'h0);
    rst_n = 1'b1;
    step();

    // 1: read, ack in first REQ cycle
    r_en = 1'b1; addr = 32'h10;
    #1;
    chk("t1_busy_issue", 32'(busy), 32'd1);
    chk("t1_req_issue", 32'(ext_req), 32'd0);
    step();
    r_en = 1'b0; addr = 32'h99;
    chk("t1_req", 32'(ext_req), 32'd1);
    chk("t1_we", 32'(ext_we), 32'd0);
    chk("t1_addr", ext_addr, 32'h10);
    ack = 1'b1; rdata_in = 32'hDEAD_BEEF;
    step();
    ack = 1'b0; rdata_in = 32'h0;
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_err", 32'(err), 32'd0);
    chk("t1_req_off", 32'(ext_req), 32'd0);
    chk("t1_busy_done", 32'(busy), 32'd0);
    chk("t1_rdata", r_data, 32'hDEAD_BEEF);
    step();
    chk("t1_done_off", 32'(done), 32'd0);

    // 2: write, ack on fifth REQ cycle
    w_en = 1'b1; addr = 32'h20; wdata = 32'h1234_5678;
    step();
    w_en = 1'b0; addr = 32'hFFFF_0000; wdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      chk("t2_req", 32'(ext_req), 32'd1);
      chk("t2_we", 32'(ext_we), 32'd1);
      chk("t2_addr", ext_addr, 32'h20);
      chk("t2_wdata", ext_wdata, 32'h1234_5678);
      chk("t2_busy", 32'(busy), 32'd1);
      chk("t2_no_done", 32'(done), 32'd0);
      if (i == 4) begin ack = 1'b1; rdata_in = 32'h5555_5555; end
      step();
    end
    ack = 1'b0;
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_err", 32'(err), 32'd0);
    chk("t2_rdata_kept", r_data, 32'hDEAD_BEEF);
    step();
    chk("t2_single_done", 32'(done), 32'd0);

    // 3: read timeout on TIMEOUT=4 instance, then a late ack
    t_r_en = 1'b1; addr = 32'h40;
    step();
    t_r_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t3_req", 32'(t_ext_req), 32'd1);
      chk("t3_no_done", 32'(t_done), 32'd0);
      step();
    end
    chk("t3_req_off", 32'(t_ext_req), 32'd0);
    chk("t3_done", 32'(t_done), 32'd1);
    chk("t3_err", 32'(t_err), 32'd1);
    chk("t3_rdata", t_r_data, 32'hFFFF_FFFF);
    t_ack = 1'b1;
    step();
    t_ack = 1'b0;
    chk("t3_late_done", 32'(t_done), 32'd0);
    chk("t3_late_err", 32'(t_err), 32'd0);
    step();
    chk("t3_idle_req", 32'(t_ext_req), 32'd0);
    chk("t3_idle_done", 32'(t_done), 32'd0);

    // 4: read and write together -> write only
    r_en = 1'b1; w_en = 1'b1; addr = 32'h30; wdata = 32'hA5A5_A5A5;
    step();
    r_en = 1'b0; w_en = 1'b0;
    chk("t4_req", 32'(ext_req), 32'd1);
    chk("t4_we", 32'(ext_we), 32'd1);
    chk("t4_addr", ext_addr, 32'h30);
    chk("t4_wdata", ext_wdata, 32'hA5A5_A5A5);
    ack = 1'b1; rdata_in = 32'h1111_1111;
    step();
    ack = 1'b0;
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_rdata_kept", r_data, 32'hDEAD_BEEF);
    step();
    chk("t4_one_access", 32'(ext_req), 32'd0);

    // 5: enable held across DONE, dropped, re-asserted two cycles later
    r_en = 1'b1; addr = 32'h50;
    step();
    ack = 1'b1; rdata_in = 32'hCAFE_0001;
    step();
    ack = 1'b0;
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_rdata", r_data, 32'hCAFE_0001);
    step();
    r_en = 1'b0;
    #1;
    chk("t5_idle_busy", 32'(busy), 32'd0);
    step();
    chk("t5_no_reissue", 32'(ext_req), 32'd0);
    r_en = 1'b1; addr = 32'h54;
    step();
    r_en = 1'b0;
    chk("t5_new_req", 32'(ext_req), 32'd1);
    chk("t5_new_addr", ext_addr, 32'h54);
    ack = 1'b1; rdata_in = 32'hCAFE_0002;
    step();
    ack = 1'b0;
    chk("t5_new_done", 32'(done), 32'd1);
    chk("t5_new_rdata", r_data, 32'hCAFE_0002);
    step();

    // 6: reset during REQ, then a fresh read
    r_en = 1'b1; addr = 32'h60;
    step();
    r_en = 1'b0;
    chk("t6_req", 32'(ext_req), 32'd1);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_req", 32'(ext_req), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_done", 32'(done), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("t6_no_done", 32'(done), 32'd0);
    chk("t6_idle_req", 32'(ext_req), 32'd0);
    r_en = 1'b1; addr = 32'h64;
    step();
    r_en = 1'b0;
    chk("t6_fresh_req", 32'(ext_req), 32'd1);
    ack = 1'b1; rdata_in = 32'h600D_600D;
    step();
    ack = 1'b0;
    chk("t6_fresh_done", 32'(done), 32'd1);
    chk("t6_fresh_err", 32'(err), 32'd0);
    chk("t6_fresh_rdata", r_data, 32'h600D_600D);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
